pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, hazard-aware pipeline stage register.
- Generic successor to the fixed-field ID/EX control latch, instantiable at IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a control bundle, NUM_DATA data lanes and a valid bit. Supports stall (hold) and flush (bubble insertion) from the hazard unit.
- Keeps saturating stall and bubble counters for pipeline performance debug.

Parameters:
CTRL_W, 12, width of the control bundle (ALU op, shift, S, load, rf, size, enable, rw, ...)
DATA_W, 32, width of one data lane
NUM_DATA, 3, number of data lanes (e.g. Rn value, Rm value, immediate); must be >= 1
CNT_W, 16, width of each performance counter
CTRL_NOP, {CTRL_W{1'b0}}, control value that encodes a NOP (no writes, no memory access, no flag update)

Ports:
CLK  input  1  clock; all state updates on its rising edge
CLR  input  1  synchronous active-high reset
stall_i  input  1  hold current contents
flush_i  input  1  replace contents with a bubble
cnt_clr_i  input  1  synchronous clear of both performance counters
valid_i  input  1  incoming instruction is valid
ctrl_i  input  CTRL_W  incoming control bundle
data_i  input  NUM_DATA*DATA_W  incoming data lanes, lane k at bits [k*DATA_W +: DATA_W]
valid_o  output  1  registered valid
ctrl_o  output  CTRL_W  registered control (CTRL_NOP whenever valid_o=0)
data_o  output  NUM_DATA*DATA_W  registered data lanes
stall_cnt_o  output  CNT_W  count of stalled cycles, saturating
bubble_cnt_o  output  CNT_W  count of bubbles captured, saturating

Behaviour:
- Reset (CLR=1 at a rising edge): valid_o=0, ctrl_o=CTRL_NOP, data_o=0, stall_cnt_o=0, bubble_cnt_o=0. CLR overrides every other input, including mid-stall and mid-flush.
- Latency: 1 cycle from input to output on a normal load. No combinational path from any input to any output.
- Per-edge priority when CLR=0: flush > stall > load.
  - Flush (flush_i=1, regardless of stall_i): valid_o<=0, ctrl_o<=CTRL_NOP, data_o<=0.
  - Stall (flush_i=0, stall_i=1): valid_o, ctrl_o and data_o all hold their values.
  - Load (flush_i=0, stall_i=0): valid_o<=valid_i; ctrl_o<=ctrl_i if valid_i=1, else CTRL_NOP; data_o<=data_i unconditionally.
- Invariant: valid_o=0 implies ctrl_o==CTRL_NOP. Ungated control from an invalid slot never reaches the next stage.
- stall_cnt_o: +1 on each edge where CLR=0, cnt_clr_i=0, flush_i=0 and stall_i=1. Counts even when valid_o=0.
- bubble_cnt_o: +1 on each edge where CLR=0, cnt_clr_i=0, and either:
  - a flush occurs, or
  - a load occurs with valid_i=0.
- Both counters saturate at 2^CNT_W-1 and never wrap. Each saturates independently.
- cnt_clr_i=1: both counters <=0 on that edge, taking precedence over increment. Pipeline contents are unaffected.
- Simultaneous flush_i and stall_i: treated as a flush. The bubble counter increments; the stall counter does not.
- Back-to-back stalls of any length are allowed. Contents remain bit-exact across them.
- After CLR deasserts, a normal load occurs on the first edge unless stall or flush is asserted.

Test Plan:
- Reset: drive CLR=1 for 2 cycles with valid_i=1, ctrl_i=0xABC, lane0=0x12345678 -> valid_o=0, ctrl_o=0x000, data_o=0, both counters 0.
- Normal flow: 3 consecutive valid loads, lane0=1,2,3, ctrl_i=0x101,0x102,0x103 -> outputs follow with 1-cycle latency; valid_o=1 throughout; counters stay 0.
- Stall hold: load lane0=0xDEADBEEF/ctrl 0x055, then stall_i=1 for 4 cycles while inputs change -> outputs unchanged for 4 cycles; stall_cnt_o=4; next unstalled edge loads the new inputs.
- Flush priority: stall_i=1 and flush_i=1 on the same edge while holding a valid entry -> valid_o=0, ctrl_o=CTRL_NOP, data_o=0; bubble_cnt_o=1; stall_cnt_o unchanged.
- Invalid gating: load with valid_i=0, ctrl_i=0xFFF, lane1=0x55 -> valid_o=0, ctrl_o=0x000, lane1 of data_o=0x55; bubble_cnt_o increments by 1.
- Saturation/clear: CNT_W=4, hold stall_i=1 for 20 cycles -> stall_cnt_o stops at 15. Then cnt_clr_i=1 with stall_i=1 -> stall_cnt_o=0 on that edge and 1 on the following edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Hazard-aware pipeline stage register: control bundle, data lanes and valid,
// with stall/flush from the hazard unit and saturating perf counters.
module pipe_stage_reg #(
    parameter int                CTRL_W   = 12,
    parameter int                DATA_W   = 32,
    parameter int                NUM_DATA = 3,
    parameter int                CNT_W    = 16,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic                       CLK,
    input  logic                       CLR,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic                       cnt_clr_i,
    input  logic                       valid_i,
    input  logic [CTRL_W-1:0]          ctrl_i,
    input  logic [NUM_DATA*DATA_W-1:0] data_i,
    output logic                       valid_o,
    output logic [CTRL_W-1:0]          ctrl_o,
    output logic [NUM_DATA*DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]           stall_cnt_o,
    output logic [CNT_W-1:0]           bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic stall_ev;
    logic load_ev;
    logic bubble_ev;

    always_comb begin
        stall_ev  = !flush_i && stall_i;
        load_ev   = !flush_i && !stall_i;
        bubble_ev = flush_i || (load_ev && !valid_i);
    end

    // Control is gated on valid so an invalid slot always carries a NOP.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            valid_o <= 1'b0;
            ctrl_o  <= CTRL_NOP;
            data_o  <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            ctrl_o  <= CTRL_NOP;
            data_o  <= '0;
        end else if (load_ev) begin
            valid_o <= valid_i;
            ctrl_o  <= valid_i ? ctrl_i : CTRL_NOP;
            data_o  <= data_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR || cnt_clr_i) begin
            stall_cnt_o <= '0;
        end else if (stall_ev && stall_cnt_o != CNT_MAX) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR || cnt_clr_i) begin
            bubble_cnt_o <= '0;
        end else if (bubble_ev && bubble_cnt_o != CNT_MAX) begin
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (CNT_W=4 so saturation is reachable).
module tb_pipe_stage_reg;

    localparam int CW = 12;
    localparam int DW = 32;
    localparam int ND = 3;
    localparam int NW = 4;

    logic              CLK = 1'b0;
    logic              CLR = 1'b1;
    logic              stall_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              cnt_clr_i = 1'b0;
    logic              valid_i = 1'b0;
    logic [CW-1:0]     ctrl_i = '0;
    logic [ND*DW-1:0]  data_i = '0;
    logic              valid_o;
    logic [CW-1:0]     ctrl_o;
    logic [ND*DW-1:0]  data_o;
    logic [NW-1:0]     stall_cnt_o;
    logic [NW-1:0]     bubble_cnt_o;

    pipe_stage_reg #(
        .CTRL_W(CW), .DATA_W(DW), .NUM_DATA(ND), .CNT_W(NW), .CTRL_NOP('0)
    ) dut (
        .CLK(CLK), .CLR(CLR), .stall_i(stall_i), .flush_i(flush_i),
        .cnt_clr_i(cnt_clr_i), .valid_i(valid_i), .ctrl_i(ctrl_i),
        .data_i(data_i), .valid_o(valid_o), .ctrl_o(ctrl_o),
        .data_o(data_o), .stall_cnt_o(stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string            name;
        logic             v;
        logic [CW-1:0]    c;
        logic [ND*DW-1:0] d;
        logic [NW-1:0]    sc;
        logic [NW-1:0]    bc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [ND*DW-1:0] ln(
        input logic [DW-1:0] l0, input logic [DW-1:0] l1,
        input logic [DW-1:0] l2);
        return {l2, l1, l0};
    endfunction

    // Monitor: the stage presents a new output after every edge.
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests += 5;
            if (valid_o !== e.v) begin
                n_fail++;
                $display("FAIL %s valid_o got %b want %b", e.name, valid_o, e.v);
            end
            if (ctrl_o !== e.c) begin
                n_fail++;
                $display("FAIL %s ctrl_o got %h want %h", e.name, ctrl_o, e.c);
            end
            if (data_o !== e.d) begin
                n_fail++;
                $display("FAIL %s data_o got %h want %h", e.name, data_o, e.d);
            end
            if (stall_cnt_o !== e.sc) begin
                n_fail++;
                $display("FAIL %s stall_cnt got %0d want %0d",
                         e.name, stall_cnt_o, e.sc);
            end
            if (bubble_cnt_o !== e.bc) begin
                n_fail++;
                $display("FAIL %s bubble_cnt got %0d want %0d",
                         e.name, bubble_cnt_o, e.bc);
            end
        end
    end

    task automatic step(
        input string nm,
        input logic clr, input logic st, input logic fl, input logic cc,
        input logic vi, input logic [CW-1:0] ci, input logic [ND*DW-1:0] di,
        input logic ev, input logic [CW-1:0] ec, input logic [ND*DW-1:0] ed,
        input int esc, input int ebc);
        exp_t e;
        CLR = clr; stall_i = st; flush_i = fl; cnt_clr_i = cc;
        valid_i = vi; ctrl_i = ci; data_i = di;
        e.name = nm; e.v = ev; e.c = ec; e.d = ed;
        e.sc = NW'(esc); e.bc = NW'(ebc);
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [ND*DW-1:0] hd;
        // Reset dominates valid inputs
        for (int i = 0; i < 2; i++)
            step("reset", 1, 0, 0, 0, 1, 12'hABC, ln(32'h12345678, 0, 0),
                 0, 12'h000, '0, 0, 0);
        // Normal flow
        for (int i = 1; i <= 3; i++)
            step("load", 0, 0, 0, 0, 1, CW'(12'h100 + i), ln(i, 0, 0),
                 1, CW'(12'h100 + i), ln(i, 0, 0), 0, 0);
        // Stall hold
        hd = ln(32'hDEADBEEF, 0, 0);
        step("ld_beef", 0, 0, 0, 0, 1, 12'h055, hd, 1, 12'h055, hd, 0, 0);
        for (int i = 1; i <= 4; i++)
            step("stall", 0, 1, 0, 0, 1, 12'h0AA, ln(32'h70 + i, i, 0),
                 1, 12'h055, hd, i, 0);
        step("unstall", 0, 0, 0, 0, 1, 12'h0AA, ln(32'h77, 0, 0),
             1, 12'h0AA, ln(32'h77, 0, 0), 4, 0);
        // Flush beats stall
        step("flush_stall", 0, 1, 1, 0, 1, 12'h0BB, ln(1, 2, 3),
             0, 12'h000, '0, 4, 1);
        // Invalid slot gating
        step("invalid", 0, 0, 0, 0, 0, 12'hFFF, ln(0, 32'h55, 0),
             0, 12'h000, ln(0, 32'h55, 0), 4, 2);
        step("ld_9", 0, 0, 0, 0, 1, 12'h003, ln(9, 0, 0),
             1, 12'h003, ln(9, 0, 0), 4, 2);
        step("flush", 0, 0, 1, 0, 1, 12'h004, ln(8, 0, 0),
             0, 12'h000, '0, 4, 3);
        step("stall_bub", 0, 1, 0, 0, 1, 12'h005, ln(7, 0, 0),
             0, 12'h000, '0, 5, 3);
        // Reset mid-stall/flush, then first edge loads
        step("clr_mid", 1, 1, 1, 0, 1, 12'h006, ln(6, 0, 0),
             0, 12'h000, '0, 0, 0);
        step("post_clr", 0, 0, 0, 0, 1, 12'h010, ln(5, 0, 0),
             1, 12'h010, ln(5, 0, 0), 0, 0);
        // Stall counter saturation and clear
        for (int i = 1; i <= 20; i++)
            step("stall_sat", 0, 1, 0, 0, 1, 12'h0CC, ln(i, 0, 0),
                 1, 12'h010, ln(5, 0, 0), (i > 15) ? 15 : i, 0);
        step("cnt_clr", 0, 1, 0, 1, 1, 12'h0CC, ln(1, 0, 0),
             1, 12'h010, ln(5, 0, 0), 0, 0);
        step("after_clr", 0, 1, 0, 0, 1, 12'h0CC, ln(1, 0, 0),
             1, 12'h010, ln(5, 0, 0), 1, 0);
        // Bubble counter saturation, independent of stall counter
        for (int i = 1; i <= 18; i++)
            step("bub_sat", 0, 0, 0, 0, 0, 12'h0DD, ln(i, 0, 0),
                 0, 12'h000, ln(i, 0, 0), 1, (i > 15) ? 15 : i);
        step("clr_flush", 0, 0, 1, 1, 1, 12'h0EE, ln(3, 0, 0),
             0, 12'h000, '0, 0, 0);
        step("cc_load", 0, 0, 0, 1, 1, 12'h0EF, ln(4, 4, 4),
             1, 12'h0EF, ln(4, 4, 4), 0, 0);
        valid_i = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain queue left %0d want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
